// File: rtl/shared_resource_scheduler_if.sv
// ----------------------------------------------------------------------------
// shared_resource_scheduler_if
//
// Purpose : groups the requester-side handshake and the grant/status signals
//           of the shared resource scheduler into one bundle.
//
// Signals :
//   en       scheduler enable (gates new grants only)
//   rot_en   1 = rotating priority, 0 = fixed priority (bit0 highest)
//   req[3:0] level request per requester
//   done[3:0] per-requester release strobe (only the owner's bit counts)
//   gnt[3:0] one-hot grant or all zero
//   owner    encoded index of current/last owner
//   busy     scheduler is not idle
//   timeout  one-cycle pulse when a grant is force-revoked
//
// Modports:
//   master - requester side: drives en/rot_en/req/done, observes the rest
//   slave  - scheduler side: observes requests, drives gnt/owner/busy/timeout
// ----------------------------------------------------------------------------
interface shared_resource_scheduler_if;
    logic       en;
    logic       rot_en;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    modport master (
        output en, rot_en, req, done,
        input  gnt, owner, busy, timeout
    );

    modport slave (
        input  en, rot_en, req, done,
        output gnt, owner, busy, timeout
    );
endinterface

// File: rtl/shared_resource_scheduler.sv
// ----------------------------------------------------------------------------
// shared_resource_scheduler
//
// Purpose : shares one resource among 4 requesters. A winner is chosen in
//           IDLE by fixed priority (lowest index) or rotating priority (search
//           starts just after the last owner). The grant is held until the
//           owner pulses done or drops req, followed by one dead RELEASE cycle.
//
// Parameters:
//   MAX_HOLD  maximum cycles a grant may stay asserted (hold limit build only)
//   CNT_W     hold counter width, 2**CNT_W >= MAX_HOLD
//
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous, active-low reset
//   bus   slave modport of shared_resource_scheduler_if
//         (en, rot_en, req, done in; gnt, owner, busy, timeout out)
//
// Configuration:
//   SCHED_TIMEOUT_EN  when defined, a grant that reaches MAX_HOLD cycles is
//                     revoked and timeout pulses for one cycle. When undefined
//                     there is no hold limit and timeout is tied low.
// ----------------------------------------------------------------------------
module shared_resource_scheduler #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    shared_resource_scheduler_if.slave    bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_SAT = '1;

    logic [1:0]       state_reg;
    logic [3:0]       gnt_reg;
    logic [1:0]       owner_reg;
    logic [1:0]       last_reg;
    logic [CNT_W-1:0] hold_cnt_reg;

    // Winner search: rotate req so that the first candidate sits at bit 0,
    // pick the lowest set bit, then rotate the offset back.
    logic [1:0] search_start;
    logic [3:0] rot_req;
    logic [1:0] win_off;
    logic [1:0] winner;
    logic       release_now;

    // last resets to 3, so the first rotating search begins at index 0,
    // which is also the fixed-priority starting point.
    assign search_start = bus.rot_en ? (last_reg + 2'd1) : 2'd0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = bus.req[search_start + 2'(gi)];
        end
    endgenerate

    always_comb begin
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_off = 2'(i);
            end
        end
    end

    assign winner = search_start + win_off;

    // Only the owner's done/req bits can end the grant.
    assign release_now = bus.done[owner_reg] | ~bus.req[owner_reg];

`ifdef SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    logic timeout_reg;
`else
    // MAX_HOLD only has an effect when the hold limit is compiled in.
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= 4'b0000;
            owner_reg    <= 2'd3;
            last_reg     <= 2'd3;
            hold_cnt_reg <= '0;
`ifdef SCHED_TIMEOUT_EN
            timeout_reg  <= 1'b0;
`endif
        end else begin
`ifdef SCHED_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (bus.en && (|bus.req)) begin
                        gnt_reg      <= 4'b0001 << winner;
                        owner_reg    <= winner;
                        hold_cnt_reg <= '0;
                        state_reg    <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_cnt_reg != HOLD_SAT) begin
                        hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                    end
                    // A normal release wins over the hold limit, so timeout
                    // stays low when both happen in the same cycle.
                    if (release_now) begin
                        gnt_reg   <= 4'b0000;
                        last_reg  <= owner_reg;
                        state_reg <= RELEASE;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (hold_cnt_reg == HOLD_LAST) begin
                        gnt_reg     <= 4'b0000;
                        timeout_reg <= 1'b1;
                        last_reg    <= owner_reg;
                        state_reg   <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    gnt_reg   <= 4'b0000;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_reg;
    assign bus.owner = owner_reg;
    assign bus.busy  = (state_reg != IDLE);
`ifdef SCHED_TIMEOUT_EN
    assign bus.timeout = timeout_reg;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_shared_resource_scheduler.sv
// ----------------------------------------------------------------------------
// tb_shared_resource_scheduler
//
// Directed stimulus for shared_resource_scheduler. A behavioural model tracks
// who holds the resource and predicts gnt/owner/busy/timeout; every falling
// edge the DUT outputs are compared against it. Literal expectations pin the
// key scenarios (fixed pick, rotating order, gaps, en low, reset mid-grant).
// Define SCHED_TIMEOUT_EN for both files to exercise the hold limit.
// ----------------------------------------------------------------------------
module tb_shared_resource_scheduler;

    localparam int MAX_HOLD = 16;
`ifdef SCHED_TIMEOUT_EN
    localparam bit HOLD_LIMIT = 1'b1;
`else
    localparam bit HOLD_LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shared_resource_scheduler_if bus ();

    shared_resource_scheduler #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // m_holder: index holding the resource, -1 when nobody does.
    // m_cool  : the single dead cycle right after a release.
    // m_held  : number of cycles the current grant has been visible.
    int m_holder = -1;
    int m_owner  = 3;
    int m_last   = 3;
    int m_held   = 0;
    bit m_cool   = 1'b0;
    bit m_to     = 1'b0;

    always @(posedge clk or negedge rst) begin : model_step
        int base;
        int pick;
        if (!rst) begin
            m_holder <= -1;
            m_owner  <= 3;
            m_last   <= 3;
            m_held   <= 0;
            m_cool   <= 1'b0;
            m_to     <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_holder >= 0) begin
                if (bus.done[m_holder] || !bus.req[m_holder]) begin
                    m_last   <= m_holder;
                    m_holder <= -1;
                    m_cool   <= 1'b1;
                end else if (HOLD_LIMIT && m_held == MAX_HOLD) begin
                    m_last   <= m_holder;
                    m_holder <= -1;
                    m_cool   <= 1'b1;
                    m_to     <= 1'b1;
                end else begin
                    m_held <= m_held + 1;
                end
            end else if (m_cool) begin
                m_cool <= 1'b0;
            end else if (bus.en && bus.req != 4'b0000) begin
                base = bus.rot_en ? m_last : 3;
                pick = -1;
                for (int k = 4; k >= 1; k--) begin
                    if (bus.req[(base + k) % 4]) pick = (base + k) % 4;
                end
                m_holder <= pick;
                m_owner  <= pick;
                m_held   <= 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [3:0] e_gnt;
        logic [1:0] e_owner;
        e_gnt   = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
        e_owner = m_owner[1:0];
        check("model_gnt", bus.gnt, e_gnt);
        check("model_owner", bus.owner, e_owner);
        check("model_busy", bus.busy, (m_holder >= 0) || m_cool);
        check("model_timeout", bus.timeout, m_to);
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    logic [3:0] rot_exp [5];
    logic [3:0] drv;
    int         low;
    int         hi;

    initial begin
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b0;
        bus.en = 1'b0;
        bus.rot_en = 1'b0;
        bus.req = 4'b0000;
        bus.done = 4'b0000;
        cyc(3);
        check("reset_gnt", bus.gnt, 4'b0000);
        check("reset_owner", bus.owner, 2'd3);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_timeout", bus.timeout, 1'b0);
        $display("txn reset: gnt=%b owner=%0d busy=%0d", bus.gnt, bus.owner, bus.busy);
        rst = 1'b1;
        cyc(1);

        // Fixed priority: 1010 -> index 1
        bus.en = 1'b1;
        bus.rot_en = 1'b0;
        bus.req = 4'b1010;
        cyc(1);
        check("fixed_gnt", bus.gnt, 4'b0010);
        check("fixed_owner", bus.owner, 2'd1);
        check("fixed_busy", bus.busy, 1'b1);
        $display("txn fixed: gnt=%b owner=%0d", bus.gnt, bus.owner);
        bus.done = 4'b0010;
        bus.req = 4'b0000;
        cyc(1);
        check("fixed_rel_gnt", bus.gnt, 4'b0000);
        check("fixed_rel_busy", bus.busy, 1'b1);
        check("fixed_rel_owner", bus.owner, 2'd1);
        bus.done = 4'b0000;
        cyc(1);
        check("fixed_idle_busy", bus.busy, 1'b0);
        cyc(1);

        // Rotating priority from reset, all requesting, done after 3 cycles
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        bus.rot_en = 1'b1;
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            low = 0;
            while (bus.gnt == 4'b0000 && low < 20) begin
                cyc(1);
                low++;
            end
            check("rot_gnt", bus.gnt, rot_exp[g]);
            if (g == 0) check("rot_latency", low, 1);
            else        check("rot_gap", low, 2);
            $display("txn rotate %0d: gnt=%b low_cycles=%0d", g, bus.gnt, low);
            cyc(2);
            drv = bus.gnt;
            bus.done = drv;
            cyc(1);
            bus.done = 4'b0000;
        end

        // Release by req drop: owner 2 drops req[2], requester 3 is next
        bus.req = 4'b1100;
        cyc(2);
        check("drop_gnt", bus.gnt, 4'b0100);
        check("drop_owner", bus.owner, 2'd2);
        cyc(1);
        bus.req = 4'b1000;
        cyc(1);
        check("drop_rel_gnt", bus.gnt, 4'b0000);
        check("drop_rel_busy", bus.busy, 1'b1);
        check("drop_rel_owner", bus.owner, 2'd2);
        cyc(1);
        check("drop_idle_gnt", bus.gnt, 4'b0000);
        check("drop_idle_busy", bus.busy, 1'b0);
        cyc(1);
        check("drop_next_gnt", bus.gnt, 4'b1000);
        check("drop_next_owner", bus.owner, 2'd3);
        $display("txn req-drop: next gnt=%b owner=%0d", bus.gnt, bus.owner);
        bus.done = 4'b1000;
        cyc(1);
        bus.done = 4'b0000;
        bus.req = 4'b0000;
        cyc(2);

        // en low does not revoke a live grant; non-owner done ignored
        bus.rot_en = 1'b0;
        bus.req = 4'b0011;
        cyc(1);
        check("en_grant", bus.gnt, 4'b0001);
        bus.en = 1'b0;
        bus.done = 4'b0010;
        cyc(1);
        bus.done = 4'b0000;
        bus.rot_en = 1'b1;
        cyc(3);
        check("en_low_keep", bus.gnt, 4'b0001);
        bus.done = 4'b0001;
        cyc(1);
        bus.done = 4'b0000;
        check("en_low_rel", bus.gnt, 4'b0000);
        cyc(4);
        check("en_low_no_new", bus.gnt, 4'b0000);
        check("en_low_idle", bus.busy, 1'b0);
        bus.en = 1'b1;
        bus.rot_en = 1'b0;
        cyc(1);
        check("en_high_gnt", bus.gnt, 4'b0001);
        $display("txn en-gate: gnt=%b after en=1", bus.gnt);

        // Asynchronous reset in the middle of a grant
        cyc(2);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_gnt", bus.gnt, 4'b0000);
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_owner", bus.owner, 2'd3);
        cyc(1);
        rst = 1'b1;
        bus.rot_en = 1'b1;
        cyc(1);
        check("post_rst_gnt", bus.gnt, 4'b0001);
        check("post_rst_owner", bus.owner, 2'd0);
        $display("txn reset-mid: regrant gnt=%b", bus.gnt);
        bus.done = 4'b0001;
        cyc(1);
        bus.done = 4'b0000;
        bus.req = 4'b0000;
        cyc(3);

`ifdef SCHED_TIMEOUT_EN
        // Hold limit: single requester never releases
        bus.rot_en = 1'b0;
        bus.req = 4'b0001;
        cyc(1);
        hi = 0;
        while (bus.gnt == 4'b0001 && hi < 40) begin
            hi++;
            cyc(1);
        end
        check("to_hold_cycles", hi, MAX_HOLD);
        check("to_pulse", bus.timeout, 1'b1);
        check("to_rel_gnt", bus.gnt, 4'b0000);
        cyc(1);
        check("to_pulse_end", bus.timeout, 1'b0);
        check("to_idle_gnt", bus.gnt, 4'b0000);
        cyc(1);
        check("to_regrant", bus.gnt, 4'b0001);
        $display("txn timeout: held=%0d cycles, regrant gnt=%b", hi, bus.gnt);
        bus.req = 4'b0000;
        cyc(3);
`endif

        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
